fp16_adder: RTL and testbench



---
 rtl/fp16_pkg.sv | 40 ++++
 rtl/fp16_lzc.sv | 19 +
 rtl/fp16_adder.sv | 145 ++++++++++++++
 tb/tb_fp16_adder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 format constants, operand/stage types and the operand unpack helper.
package fp16_pkg;

    localparam int unsigned FP_W   = 16;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned BIAS   = 15;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned EXT_W  = SIG_W + 3;
    localparam int unsigned LZC_W  = 4;

    localparam logic [FP_W-1:0]  QNAN    = 16'h7E00;
    localparam logic [FP_W-1:0]  POS_INF = 16'h7C00;
    localparam logic [FP_W-1:0]  NEG_INF = 16'hFC00;
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp16_unpacked_t;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF
    } special_e;

    // Subnormals get hidden bit 0 and effective exponent 1.
    function automatic fp16_unpacked_t unpack(input logic [FP_W-1:0] x);
        fp16_unpacked_t u;
        logic           normal;
        normal = (x[FRAC_W +: EXP_W] != '0);
        u.sign = x[FP_W-1];
        u.exp  = normal ? x[FRAC_W +: EXP_W] : EXP_W'(1);
        u.sig  = {normal, x[FRAC_W-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero counter over the stage-1 extended significand; all-zero input yields EXT_W.
module fp16_lzc
    import fp16_pkg::*;
(
    input  logic [EXT_W-1:0] sig_i,
    output logic [LZC_W-1:0] zeros_o
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        zeros_o = LZC_W'(EXT_W);
        for (int unsigned i = 0; i < EXT_W; i++) begin
            if (sig_i[i]) begin
                zeros_o = LZC_W'(EXT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_adder.sv
// Pipelined binary16 adder, round-to-nearest-even; operands captured on the sampling
// edge, stage 1 aligns and adds, stage 2 normalizes, rounds and packs.
module fp16_adder
    import fp16_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] out
);

    localparam int unsigned ALIGN_MAX = SIG_W + 2;
    localparam int unsigned WIDE_W    = SIG_W + 2 + ALIGN_MAX;
    localparam int unsigned EXPX_W    = EXP_W + 1;

    logic [FP_W-1:0]   a_q, b_q;
    logic [EXT_W-1:0]  sum_q, sum_d;
    logic [EXPX_W-1:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    special_e          spc_q, spc_d;
    logic [FP_W-1:0]   out_q, out_d;

    fp16_unpacked_t    op_a, op_b, op_l, op_s;
    logic              a_nan, b_nan, a_inf, b_inf, eff_sub;
    logic [EXP_W-1:0]  exp_diff, shamt;
    logic [WIDE_W-1:0] s_wide;
    logic [EXT_W-1:0]  l_ext, s_ext;
    logic [EXT_W:0]    sum_full;

    logic [LZC_W-1:0]  lz, sh;
    logic [EXPX_W-1:0] room, exp_n, exp_f;
    logic [EXT_W-1:0]  norm;
    logic [SIG_W-1:0]  mant;
    logic [SIG_W:0]    mant_r;
    logic [FRAC_W-1:0] frac;
    logic              round_up;

    // Stage 1: unpack, swap, align, add/sub, classify specials.
    always_comb begin
        op_a  = unpack(a_q);
        op_b  = unpack(b_q);
        a_nan = (a_q[FRAC_W +: EXP_W] == EXP_MAX) && (a_q[FRAC_W-1:0] != '0);
        b_nan = (b_q[FRAC_W +: EXP_W] == EXP_MAX) && (b_q[FRAC_W-1:0] != '0);
        a_inf = (a_q[FRAC_W +: EXP_W] == EXP_MAX) && (a_q[FRAC_W-1:0] == '0);
        b_inf = (b_q[FRAC_W +: EXP_W] == EXP_MAX) && (b_q[FRAC_W-1:0] == '0);

        op_l = op_a;
        op_s = op_b;
        if (b_q[FP_W-2:0] > a_q[FP_W-2:0]) begin
            op_l = op_b;
            op_s = op_a;
        end
        eff_sub = op_l.sign ^ op_s.sign;

        // Beyond ALIGN_MAX the smaller operand only contributes sticky.
        exp_diff = op_l.exp - op_s.exp;
        shamt    = (exp_diff > EXP_W'(ALIGN_MAX)) ? EXP_W'(ALIGN_MAX) : exp_diff;
        s_wide   = {op_s.sig, 2'b00, {ALIGN_MAX{1'b0}}} >> shamt;
        s_ext    = {s_wide[WIDE_W-1 -: SIG_W+2], |s_wide[ALIGN_MAX-1:0]};
        l_ext    = {op_l.sig, 3'b000};

        sum_full = eff_sub ? ({1'b0, l_ext} - {1'b0, s_ext})
                           : ({1'b0, l_ext} + {1'b0, s_ext});

        sum_d = sum_full[EXT_W-1:0];
        exp_d = {1'b0, op_l.exp};
        if (!eff_sub && sum_full[EXT_W]) begin
            sum_d = {sum_full[EXT_W:2], sum_full[1] | sum_full[0]};
            exp_d = {1'b0, op_l.exp} + EXPX_W'(1);
        end

        sign_d = (eff_sub && (sum_full == '0)) ? 1'b0 : op_l.sign;
        spc_d  = SPC_NONE;
        if (a_nan || b_nan || (a_inf && b_inf && (a_q[FP_W-1] != b_q[FP_W-1]))) begin
            spc_d = SPC_NAN;
        end else if (a_inf) begin
            spc_d  = SPC_INF;
            sign_d = a_q[FP_W-1];
        end else if (b_inf) begin
            spc_d  = SPC_INF;
            sign_d = b_q[FP_W-1];
        end
    end

    fp16_lzc u_lzc (
        .sig_i   (sum_q),
        .zeros_o (lz)
    );

    // Stage 2: normalize (clamped at exponent 1), round to nearest even, pack.
    always_comb begin
        room = exp_q - EXPX_W'(1);
        sh   = lz;
        if (EXPX_W'(lz) > room) begin
            sh = LZC_W'(room);
        end
        norm     = sum_q << sh;
        exp_n    = exp_q - EXPX_W'(sh);
        mant     = norm[EXT_W-1 -: SIG_W];
        round_up = norm[2] & (norm[1] | norm[0] | mant[0]);
        mant_r   = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};

        if (mant_r[SIG_W]) begin
            exp_f = exp_n + EXPX_W'(1);
            frac  = mant_r[FRAC_W:1];
        end else begin
            exp_f = mant_r[FRAC_W] ? exp_n : '0;
            frac  = mant_r[FRAC_W-1:0];
        end

        out_d = {sign_q, exp_f[EXP_W-1:0], frac};
        if (exp_f >= {1'b0, EXP_MAX}) begin
            out_d = sign_q ? NEG_INF : POS_INF;
        end
        case (spc_q)
            SPC_NAN: out_d = QNAN;
            SPC_INF: out_d = sign_q ? NEG_INF : POS_INF;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            spc_q  <= SPC_NONE;
            out_q  <= '0;
        end else begin
            a_q    <= a;
            b_q    <= b;
            sum_q  <= sum_d;
            exp_q  <= exp_d;
            sign_q <= sign_d;
            spc_q  <= spc_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_fp16_adder.sv
// Directed bench for fp16_adder: streamed vectors at full rate, plus asynchronous reset behaviour.
module tb_fp16_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b, out;
    int          n_cmp = 0;
    int          n_bad = 0;

    fp16_adder dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .out (out)
    );

    always #5 clk = ~clk;

    localparam int NV = 20;
    logic [15:0] va [NV] = '{16'h4B60, 16'h4766, 16'hCB60, 16'h3C00, 16'h8000,
                             16'h3C00, 16'h3C01, 16'h3C00, 16'h7BFF, 16'h7C00,
                             16'h7E01, 16'hFC00, 16'h0001, 16'h03FF, 16'h0400,
                             16'h0000, 16'h8000, 16'h3C00, 16'hC000, 16'h3C00};
    logic [15:0] vb [NV] = '{16'h4700, 16'h4826, 16'h4700, 16'hBC00, 16'h8000,
                             16'h1000, 16'h1000, 16'h0001, 16'h7BFF, 16'hFC00,
                             16'h3C00, 16'h4000, 16'h0001, 16'h0001, 16'h8001,
                             16'h8000, 16'h0000, 16'h7E00, 16'h3C00, 16'hC000};
    logic [15:0] ve [NV] = '{16'h4D70, 16'h4BD9, 16'hC7C0, 16'h0000, 16'h8000,
                             16'h3C00, 16'h3C02, 16'h3C00, 16'h7C00, 16'h7E00,
                             16'h7E00, 16'hFC00, 16'h0002, 16'h0400, 16'h03FF,
                             16'h0000, 16'h0000, 16'h7E00, 16'hBC00, 16'hBC00};

    initial begin
        rst = 1'b0;
        a   = 16'h0000;
        b   = 16'h0000;
        #3;
        n_cmp++;
        assert (out === 16'h0000) else begin
            n_bad++;
            $error("FAIL reset_init: got %h expected %h", out, 16'h0000);
        end
        @(posedge clk); #1;
        n_cmp++;
        assert (out === 16'h0000) else begin
            n_bad++;
            $error("FAIL reset_hold: got %h expected %h", out, 16'h0000);
        end
        rst = 1'b1;

        // One new pair per cycle; result for pair i is checked after edge i+2.
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                a = va[i];
                b = vb[i];
            end
            @(posedge clk); #1;
            if (i >= 2) begin
                n_cmp++;
                assert (out === ve[i-2]) else begin
                    n_bad++;
                    $error("FAIL vec%0d %h+%h: got %h expected %h", i - 2, va[i-2], vb[i-2], out, ve[i-2]);
                end
            end
        end

        // Put a nonzero result on the output, then reset between edges.
        a = 16'h4B60;
        b = 16'h4700;
        @(posedge clk); #1;
        a = 16'h7BFF;
        b = 16'h7BFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        assert (out === 16'h4D70) else begin
            n_bad++;
            $error("FAIL pre_reset: got %h expected %h", out, 16'h4D70);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        assert (out === 16'h0000) else begin
            n_bad++;
            $error("FAIL reset_async: got %h expected %h", out, 16'h0000);
        end
        @(posedge clk); #1;
        n_cmp++;
        assert (out === 16'h0000) else begin
            n_bad++;
            $error("FAIL reset_low_clocked: got %h expected %h", out, 16'h0000);
        end

        a = 16'h4766;
        b = 16'h4826;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        a = 16'h3C00;
        b = 16'h3C00;
        @(posedge clk); #1;
        a = 16'h0000;
        b = 16'h0000;
        @(posedge clk); #1;
        n_cmp++;
        assert (out === 16'h4BD9) else begin
            n_bad++;
            $error("FAIL post_reset_first: got %h expected %h", out, 16'h4BD9);
        end
        @(posedge clk); #1;
        n_cmp++;
        assert (out === 16'h4000) else begin
            n_bad++;
            $error("FAIL post_reset_second: got %h expected %h", out, 16'h4000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
